// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RESP
  } state_e;

  localparam logic [XLEN-1:0] DIV0_Q  = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
endpackage

// File: rtl/div_sign_ctrl_if.sv
// Request/response handshake plus the divider-core port bundle.
interface div_sign_ctrl_if;
  import div_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  core_a;
  logic [XLEN-1:0]  core_b;
  logic             core_start;
  logic [XLEN-1:0]  core_q;
  logic [XLEN-1:0]  core_r;
  logic             core_busy;

  // master: requester/consumer and core side; slave: the sequencer
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
           core_q, core_r, core_busy,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, core_a, core_b, core_start
  );
  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
           core_q, core_r, core_busy,
    output req_ready, rsp_valid, rsp_data, rsp_tag, core_a, core_b, core_start
  );
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; |INT_MIN| wraps to INT_MIN, which is right as unsigned.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] i_in,
  input  logic         i_neg,
  output logic [W-1:0] o_out
);
  assign o_out = i_neg ? (~i_in + W'(1)) : i_in;
endmodule

// File: rtl/div_sign_ctrl.sv
// Signed front/back end around the unsigned divider core: special cases, magnitudes, result sign.
module div_sign_ctrl
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rstlow,
  div_sign_ctrl_if.slave  bus
);
  state_e           r_state;
  logic             r_rem;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_data;
  logic [XLEN-1:0]  r_core_a;
  logic [XLEN-1:0]  r_core_b;
  logic             r_start;
  logic             r_req_ready;
  logic             r_rsp_valid;

  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_raw;
  logic            w_res_neg;
  logic [XLEN-1:0] w_res;

  assign w_signed = ~bus.req_op[0];
  assign w_neg_a  = w_signed & bus.req_rs1[XLEN-1];
  assign w_neg_b  = w_signed & bus.req_rs2[XLEN-1];

  // Quotient takes the xor of operand signs; remainder follows the dividend.
  assign w_raw     = r_rem ? bus.core_r : bus.core_q;
  assign w_res_neg = r_rem ? r_neg_a : (r_neg_a ^ r_neg_b);

  div_sign_fix #(.W(XLEN)) u_fix_a   (.i_in(bus.req_rs1), .i_neg(w_neg_a),   .o_out(w_abs_a));
  div_sign_fix #(.W(XLEN)) u_fix_b   (.i_in(bus.req_rs2), .i_neg(w_neg_b),   .o_out(w_abs_b));
  div_sign_fix #(.W(XLEN)) u_fix_res (.i_in(w_raw),       .i_neg(w_res_neg), .o_out(w_res));

  always_ff @(posedge clk or negedge rstlow) begin
    if (!rstlow) begin
      r_state     <= S_IDLE;
      r_rem       <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_tag       <= '0;
      r_data      <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_start     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_rem       <= bus.req_op[1];
            r_tag       <= bus.req_tag;
            r_neg_a     <= w_neg_a;
            r_neg_b     <= w_neg_b;
            r_req_ready <= 1'b0;
            if (bus.req_rs2 == '0) begin
              r_data      <= bus.req_op[1] ? bus.req_rs1 : DIV0_Q;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_signed && bus.req_rs1 == INT_MIN && bus.req_rs2 == '1) begin
              r_data      <= bus.req_op[1] ? '0 : INT_MIN;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_core_a <= w_abs_a;
              r_core_b <= w_abs_b;
              r_start  <= 1'b1;
              r_state  <= S_START;
            end
          end
        end
        S_START:   r_state <= S_WAIT_HI;
        S_WAIT_HI: if (bus.core_busy) r_state <= S_WAIT_LO;
        S_WAIT_LO: begin
          // core_q/core_r are only valid on the first not-busy cycle
          if (!bus.core_busy) begin
            r_data      <= w_res;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_data;
  assign bus.rsp_tag    = r_tag;
  assign bus.core_a     = r_core_a;
  assign bus.core_b     = r_core_b;
  assign bus.core_start = r_start;
endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl with a cycle-accurate model of the 32-cycle divider core.
module tb_div_sign_ctrl;
  logic clk;
  logic rstlow;
  int   checks;
  int   failures;
  int   starts;
  int   cnt;

  div_sign_ctrl_if bus();

  div_sign_ctrl dut (.clk(clk), .rstlow(rstlow), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: start seen at edge S, busy visible after S+1..S+32, result valid only at cnt==34.
  always @(posedge clk or negedge rstlow) begin
    if (!rstlow) cnt <= 0;
    else if (cnt == 0 && bus.core_start) cnt <= 1;
    else if (cnt != 0) cnt <= (cnt == 34) ? 0 : cnt + 1;
  end
  assign bus.core_busy = (cnt >= 2) && (cnt <= 33);
  assign bus.core_q    = (cnt == 34) ? bus.core_a / bus.core_b : 32'hDEAD_BEEF;
  assign bus.core_r    = (cnt == 34) ? bus.core_a % bus.core_b : 32'hDEAD_BEEF;

  always @(negedge clk) if (bus.core_start) starts++;

  // Called just after a negedge; returns just after the negedge where rsp_valid is seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] data, output logic [4:0] rtag,
                       output int lat, output int wacc);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
    starts = 0;
    wacc = 0;
    while (!bus.req_ready && wacc < 50) begin
      @(negedge clk);
      wacc++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = bus.rsp_data;
    rtag = bus.rsp_tag;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstlow = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_tag = '0; bus.rsp_ready = 1'b0;
    #22;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_tag !== 5'h0) begin failures++; $display("FAIL reset_rsp_tag got=%h exp=0", bus.rsp_tag); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", bus.core_start); end
    checks++; if ({bus.core_a, bus.core_b} !== 64'h0) begin failures++; $display("FAIL reset_core_ab got=%h exp=0", {bus.core_a, bus.core_b}); end
    @(negedge clk);
    rstlow = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_div_basic();
    logic [31:0] d; logic [4:0] t; int lat, w;
    issue(2'b00, 32'd100, 32'd7, 5'd3, d, t, lat, w);
    checks++; if (d !== 32'd14) begin failures++; $display("FAIL div_100_7 got=%h exp=%h", d, 32'd14); end
    checks++; if (lat !== 36) begin failures++; $display("FAIL div_latency got=%0d exp=36", lat); end
    checks++; if (t !== 5'd3) begin failures++; $display("FAIL div_tag got=%0d exp=3", t); end
    checks++; if (starts !== 1) begin failures++; $display("FAIL div_start_pulses got=%0d exp=1", starts); end
    ack();
  endtask

  task automatic test_signed();
    logic [1:0]  ops [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'd2};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] d; logic [4:0] t; int lat, w;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 10), d, t, lat, w);
      checks++; if (d !== exp[i]) begin failures++; $display("FAIL signed_case%0d got=%h exp=%h", i, d, exp[i]); end
      checks++; if (lat !== 36) begin failures++; $display("FAIL signed_lat%0d got=%0d exp=36", i, lat); end
      ack();
    end
    issue(2'b00, 32'h8000_0000, 32'd2, 5'd16, d, t, lat, w);
    checks++; if (d !== 32'hC000_0000) begin failures++; $display("FAIL div_intmin_2 got=%h exp=c0000000", d); end
    ack();
  endtask

  task automatic test_special();
    logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b10};
    logic [31:0] as  [5] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp [5] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] d; logic [4:0] t; int lat, w;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 20), d, t, lat, w);
      checks++; if (d !== exp[i]) begin failures++; $display("FAIL special_case%0d got=%h exp=%h", i, d, exp[i]); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL special_lat%0d got=%0d exp=1", i, lat); end
      checks++; if (starts !== 0) begin failures++; $display("FAIL special_start%0d got=%0d exp=0", i, starts); end
      checks++; if (t !== 5'(i + 20)) begin failures++; $display("FAIL special_tag%0d got=%0d exp=%0d", i, t, i + 20); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [4:0] t; int lat, w;
    issue(2'b01, 32'd1000, 32'd10, 5'd7, d, t, lat, w);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.req_ready} !== {1'b1, 32'd100, 5'd7, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d got=v%b d=%h t=%0d rdy=%b exp=v1 d=00000064 t=7 rdy=0",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.req_ready);
      end
      @(negedge clk);
    end
    ack();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_ack got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL valid_after_ack got=%b exp=0", bus.rsp_valid); end
    issue(2'b01, 32'd9, 32'd4, 5'd8, d, t, lat, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL b2b_accept_wait got=%0d exp=0", w); end
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL b2b_divu_9_4 got=%h exp=2", d); end
    ack();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_rs1 = 32'd1000; bus.req_rs2 = 32'd3; bus.req_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checks++; if ({bus.core_a, bus.rsp_valid} !== {32'd1000, 1'b0}) begin failures++; $display("FAIL mid_div_state a=%h v=%b exp a=000003e8 v=0", bus.core_a, bus.rsp_valid); end
    rstlow = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.core_start, bus.core_a, bus.core_b} !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset got=rdy%b v%b d=%h t=%0d s=%b a=%h b=%h exp rdy1 v0 all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.core_start, bus.core_a, bus.core_b);
    end
    @(negedge clk);
    rstlow = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_after_reset();
    logic [31:0] d; logic [4:0] t; int lat, w;
    issue(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd21, d, t, lat, w);
    checks++; if (d !== 32'hFFFF_FFFA) begin failures++; $display("FAIL post_reset_div got=%h exp=fffffffa", d); end
    checks++; if (t !== 5'd21) begin failures++; $display("FAIL post_reset_tag got=%0d exp=21", t); end
    checks++; if (lat !== 36) begin failures++; $display("FAIL post_reset_lat got=%0d exp=36", lat); end
    ack();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    starts = 0;
    test_reset();
    test_div_basic();
    test_signed();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
